// File: rtl/iir_shift_filter.sv
// Second-order IIR with shift-only feedback gains and a saturating output.
// y[n] = x[n] - x[n-1] + x[n-2] + x[n-3] + (y[n-1] >>> S1) + (y[n-2] >>> S2)
module iir_shift_filter #(
  parameter int W  = 8,
  parameter int S1 = 1,
  parameter int S2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                in_valid,
  input  logic signed [W-1:0] x,
  output logic                out_valid,
  output logic signed [W-1:0] y,
  output logic                sat,
  output logic                ovf_sticky
);

  localparam int AW = W + 3;

  logic signed [W-1:0]  x1_q, x2_q, x3_q, y1_q, y2_q, y_q;
  logic signed [W-1:0]  x1_d, x2_d, x3_d, y1_d, y2_d, y_d;
  logic                 sat_q, sat_d, ovf_q, ovf_d, vld_q, vld_d;

  logic signed [W-1:0]  ys1, ys2, ysat;
  logic signed [AW-1:0] acc;
  logic [3:0]           acc_hi;
  logic                 clamp;

  always_comb begin
    ys1 = y1_q >>> S1;
    ys2 = y2_q >>> S2;
    acc = {{3{x[W-1]}},    x}
        - {{3{x1_q[W-1]}}, x1_q}
        + {{3{x2_q[W-1]}}, x2_q}
        + {{3{x3_q[W-1]}}, x3_q}
        + {{3{ys1[W-1]}},  ys1}
        + {{3{ys2[W-1]}},  ys2};
    // The sum fits W bits only when the top four bits are all equal.
    acc_hi = acc[AW-1:W-1];
    clamp  = (acc_hi != 4'b0000) && (acc_hi != 4'b1111);
    if (!clamp)
      ysat = acc[W-1:0];
    else if (acc[AW-1])
      ysat = {1'b1, {(W-1){1'b0}}};
    else
      ysat = {1'b0, {(W-1){1'b1}}};
  end

  always_comb begin
    x1_d  = x1_q;
    x2_d  = x2_q;
    x3_d  = x3_q;
    y1_d  = y1_q;
    y2_d  = y2_q;
    y_d   = y_q;
    sat_d = sat_q;
    ovf_d = ovf_q;
    vld_d = 1'b0;
    if (clr) begin
      x1_d  = '0;
      x2_d  = '0;
      x3_d  = '0;
      y1_d  = '0;
      y2_d  = '0;
      y_d   = '0;
      sat_d = 1'b0;
      ovf_d = 1'b0;
    end else if (in_valid) begin
      x1_d  = x;
      x2_d  = x1_q;
      x3_d  = x2_q;
      y1_d  = ysat;
      y2_d  = y1_q;
      y_d   = ysat;
      sat_d = clamp;
      ovf_d = ovf_q | clamp;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1_q  <= '0;
      x2_q  <= '0;
      x3_q  <= '0;
      y1_q  <= '0;
      y2_q  <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      x1_q  <= x1_d;
      x2_q  <= x2_d;
      x3_q  <= x3_d;
      y1_q  <= y1_d;
      y2_q  <= y2_d;
      y_q   <= y_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
    end
  end

  assign y          = y_q;
  assign sat        = sat_q;
  assign ovf_sticky = ovf_q;
  assign out_valid  = vld_q;

endmodule

// File: tb/tb_iir_shift_filter.sv
// Bench for iir_shift_filter: directed vectors plus random traffic against
// a sample-history reference model using plain integer arithmetic.
module tb_iir_shift_filter;

  localparam int W    = 8;
  localparam int S1   = 1;
  localparam int S2   = 2;
  localparam int YMAX = 127;
  localparam int YMIN = -128;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                clr = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] x = '0;
  logic                out_valid;
  logic signed [W-1:0] y;
  logic                sat;
  logic                ovf_sticky;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int xh[$];
  int yh[$];
  int m_y, m_sat, m_ov, m_valid;

  int imp_e[5] = '{1, -1, 0, 0, 0};

  iir_shift_filter #(.W(W), .S1(S1), .S2(S2)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .in_valid   (in_valid),
    .x          (x),
    .out_valid  (out_valid),
    .y          (y),
    .sat        (sat),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Floor division by a positive divisor (what an arithmetic shift computes).
  function automatic int fdiv(input int v, input int d);
    int q;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q--;
    return q;
  endfunction

  function automatic int xat(input int k);
    return (xh.size() > k) ? xh[xh.size()-1-k] : 0;
  endfunction

  function automatic int yat(input int k);
    return (yh.size() > k) ? yh[yh.size()-1-k] : 0;
  endfunction

  task automatic model_reset();
    xh.delete();
    yh.delete();
    m_y = 0; m_sat = 0; m_ov = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    int xn, s, c;
    if (clr) begin
      model_reset();
    end else if (in_valid) begin
      xn = int'(x);
      s  = xn - xat(0) + xat(1) + xat(2)
         + fdiv(yat(0), 2**S1) + fdiv(yat(1), 2**S2);
      c  = (s > YMAX) ? YMAX : (s < YMIN) ? YMIN : s;
      m_sat   = (c != s) ? 1 : 0;
      if (m_sat != 0) m_ov = 1;
      m_y     = c;
      m_valid = 1;
      xh.push_back(xn);
      yh.push_back(c);
      if (xh.size() > 8) begin void'(xh.pop_front()); void'(yh.pop_front()); end
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, out_valid, m_valid);
    chk({tag, ".y"}, y, m_y);
    chk({tag, ".sat"}, sat, m_sat);
    chk({tag, ".ovf"}, ovf_sticky, m_ov);
  endtask

  task automatic step(input bit v, input int xv, input bit c, input string tag);
    @(negedge clk);
    in_valid = v;
    x        = W'(xv);
    clr      = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst.y", y, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.sat", sat, 0);
    chk("rst.ovf", ovf_sticky, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i == 0) ? 1 : 0, 1'b0, "imp");
      chk("imp.y_const", y, imp_e[i]);
      chk("imp.sat_const", sat, 0);
    end

    step(1'b0, 0, 1'b1, "clr");
    step(1'b1, 127, 1'b0, "pos0"); chk("pos0.y_const", y, 127); chk("pos0.sat_const", sat, 0);
    step(1'b1, 127, 1'b0, "pos1"); chk("pos1.y_const", y, 63);  chk("pos1.sat_const", sat, 0);
    step(1'b1, 127, 1'b0, "pos2"); chk("pos2.y_const", y, 127); chk("pos2.sat_const", sat, 1);
    chk("pos2.ovf_const", ovf_sticky, 1);

    step(1'b0, 0, 1'b1, "clr");
    step(1'b1, -128, 1'b0, "neg0"); chk("neg0.y_const", y, -128); chk("neg0.sat_const", sat, 0);
    step(1'b1, -128, 1'b0, "neg1"); chk("neg1.y_const", y, -64);  chk("neg1.sat_const", sat, 0);
    step(1'b1, -128, 1'b0, "neg2"); chk("neg2.y_const", y, -128); chk("neg2.sat_const", sat, 1);
    chk("neg2.ovf_const", ovf_sticky, 1);

    step(1'b0, 0, 1'b1, "clr");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i == 0) ? 1 : 0, 1'b0, "gapv");
      chk("gapv.y_const", y, imp_e[i]);
      chk("gapv.ov_const", out_valid, 1);
      step(1'b0, 55, 1'b0, "gap");
      chk("gap.y_const", y, imp_e[i]);
      chk("gap.ov_const", out_valid, 0);
    end

    step(1'b0, 0, 1'b1, "clr");
    step(1'b1, 127, 1'b0, "cs0");
    step(1'b1, 127, 1'b0, "cs1");
    step(1'b1, 127, 1'b0, "cs2");
    step(1'b1, 127, 1'b1, "clrv");
    chk("clrv.y_const", y, 0);
    chk("clrv.ovf_const", ovf_sticky, 0);
    chk("clrv.out_valid_const", out_valid, 0);
    step(1'b1, 5, 1'b0, "post_clr");
    chk("post_clr.y_const", y, 5);

    step(1'b1, 1, 1'b0, "ar0");
    step(1'b1, 0, 1'b0, "ar1");
    reset    = 1'b0;
    in_valid = 1'b0;
    clr      = 1'b0;
    model_reset();
    #2;
    chk("async.y", y, 0);
    chk("async.out_valid", out_valid, 0);
    chk("async.sat", sat, 0);
    chk("async.ovf", ovf_sticky, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i == 0) ? 1 : 0, 1'b0, "imp2");
      chk("imp2.y_const", y, imp_e[i]);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)) - 128,
           ($urandom_range(0, 40) == 0), "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
